// File: rtl/hamming_encode_engine.sv
// Memory-mapped Hamming SECDED encoder: reads 11-bit messages, writes 16-bit
// codewords {d[11:5],p8,d[4:2],p4,d1,p2,p1,p0} back to the shared data memory.
module hamming_encode_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 30,
  parameter int AW        = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);

  localparam int CW = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP_HI,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [10:0]     msg_q, msg_d;
  logic            ack_q, ack_d;
  logic [AW-1:0]   addr_q, addr_d;

  logic [11:1]     d;
  logic            p8, p4, p2, p1, p0;
  logic [15:0]     codeword;
  logic [AW-1:0]   word_off;
  logic [AW-1:0]   src_lo;
  logic [AW-1:0]   dst_lo;
  logic            last_word;

  assign d  = msg_q;
  assign p8 = ^d[11:5];
  assign p4 = (^d[11:8]) ^ (^d[4:2]);
  assign p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
  assign p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
  assign p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;

  assign codeword = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};

  assign word_off  = AW'({cnt_q, 1'b0});
  assign src_lo    = AW'(SRC_BASE) + word_off;
  assign dst_lo    = AW'(DST_BASE) + word_off;
  assign last_word = (cnt_q == CW'(NUM_WORDS - 1));

  // The address is driven straight from the next-address value so it is
  // present during the state that uses it; addr_q only holds it when idle.
  assign mem_addr = addr_d;
  assign ack      = ack_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    msg_d       = msg_q;
    ack_d       = ack_q;
    addr_d      = addr_q;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RD_LO;
          cnt_d   = '0;
        end
      end
      RD_LO: begin
        addr_d  = src_lo;
        state_d = RD_HI;
      end
      RD_HI: begin
        addr_d     = src_lo + AW'(1);
        msg_d[7:0] = mem_rd_data;
        state_d    = CAP_HI;
      end
      CAP_HI: begin
        msg_d[10:8] = mem_rd_data[2:0];
        state_d     = WR_LO;
      end
      WR_LO: begin
        mem_wr_en   = 1'b1;
        addr_d      = dst_lo;
        mem_wr_data = codeword[7:0];
        state_d     = WR_HI;
      end
      WR_HI: begin
        mem_wr_en   = 1'b1;
        addr_d      = dst_lo + AW'(1);
        mem_wr_data = codeword[15:8];
        if (last_word) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = RD_LO;
        end
      end
      DONE: begin
        if (req) begin
          state_d = RD_LO;
          cnt_d   = '0;
          ack_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      msg_q   <= '0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: doc/hamming_encode_engine.md
# hamming_encode_engine

Memory-mapped Hamming SECDED encoder engine: the transmit-side counterpart of the program-2 decoder. On a `req` pulse it reads NUM_WORDS 11-bit messages from data memory and computes the four Hamming parity bits plus the overall parity bit p0 for each. It writes each 16-bit codeword back to data memory, then raises `ack`. It shares the data-memory port with the core and produces the codeword layout the decoder consumes.

## Interface
- NUM_WORDS, 15: messages encoded per request.
- SRC_BASE, 0: byte address of message 0. Low byte is at SRC_BASE+2i; high byte is at SRC_BASE+2i+1.
- DST_BASE, 30: byte address of codeword 0. Low byte is at DST_BASE+2i; high byte is at DST_BASE+2i+1.
- AW, 8: memory address width.
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  start request, sampled only in IDLE and DONE.
- ack  out  1  done flag, registered, level.
- mem_addr  out  AW  data-memory byte address.
- mem_rd_data  in  8  read data; valid one cycle after the address is presented (synchronous read).
- mem_wr_en  out  1  write strobe; the write commits at the rising edge while high.
- mem_wr_data  out  8  write byte.

## Operation
- Message i is 11 bits, d[11:1]: d[8:1] = low byte; d[11:9] = high byte bits [2:0]. High byte bits [7:3] are ignored.
- Parity bits:
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d[11:1] ^ p8 ^ p4 ^ p2 ^ p1 (even overall parity)
- Codeword = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0}. Parity is computed combinationally from the captured message register.
- FSM states: IDLE, RD_LO, RD_HI, CAP_HI, WR_LO, WR_HI, DONE.
  - IDLE: `req`=1 → RD_LO and clear the word counter i.
  - RD_LO: mem_addr = SRC_BASE+2i → RD_HI.
  - RD_HI: mem_addr = SRC_BASE+2i+1; capture mem_rd_data into d[8:1] → CAP_HI.
  - CAP_HI: capture mem_rd_data[2:0] into d[11:9] → WR_LO.
  - WR_LO: mem_wr_en=1, mem_addr = DST_BASE+2i, mem_wr_data = codeword[7:0] → WR_HI.
  - WR_HI: mem_wr_en=1, mem_addr = DST_BASE+2i+1, mem_wr_data = codeword[15:8]. If i = NUM_WORDS-1 → DONE; otherwise increment i → RD_LO.
  - DONE: ack=1. `req`=1 → RD_LO with i cleared (restart); otherwise stay in DONE.
- `req` in any busy state is ignored; no queueing.
- Word counter width is clog2(NUM_WORDS+1). It never wraps during a run.
- mem_wr_en is 0 in every state except WR_LO and WR_HI. mem_addr is don't-care but stable (hold last value) in IDLE and DONE.
- Source and destination regions must not overlap; the engine performs no overlap check.

## Timing
- Reset values: state=IDLE, ack=0, mem_wr_en=0, mem_wr_data=0, mem_addr=0, counter=0, message register=0.
- reset_n low mid-run aborts immediately: the FSM goes to IDLE and ack=0. Bytes already written remain in memory; there is no rollback.
- Five cycles per word. With the `req`-sampling edge as edge 0, the FSM enters DONE at edge 5·NUM_WORDS (75 for the default) and `ack` is high from that edge onward.
- `ack` stays high until `req` is sampled in DONE. `ack` falls on that same edge.
- A single-cycle `req` pulse is sufficient. `req` held high across DONE restarts the engine on the first DONE cycle, so `ack` is high for exactly one cycle.

## Test plan
- Message 0x000 (bytes 0x00, 0x00) → codeword 0x0000; memory [30]=0x00, [31]=0x00.
- Message 0x7FF (bytes 0xFF, 0x07) → 0xFFFF. Message 0x001 → 0x000F. Message 0x400 (bytes 0x00, 0x04) → 0x8117: low byte 0x17, high byte 0x81.
- High byte 0xF8 with low byte 0x00 (junk in bits [7:3]) → 0x0000, proving the junk bits are ignored.
- Load 15 random messages, pulse `req` for 1 cycle, then wait for `ack`.
  - `ack` must rise exactly 75 edges after the sampling edge.
  - All 15 codewords must match a reference model.
  - Feeding each codeword to the decoder must yield flags 2'b00 and the original message.
  - Flipping any single bit of a codeword must make the decoder report flags 2'b01 with the corrected message.
- Pulse `req` in RD_HI of word 3 → ignored: total latency is still 75 cycles and the results are unchanged. A second `req` in DONE → full rerun, and `ack` drops on the sampling edge.
- Assert reset_n low at word 7, WR_LO → ack=0, mem_wr_en=0, state IDLE. Words 0–6 and low byte 7 are written. A new `req` then completes all 15 words correctly.
